// File: rtl/link_collision_detector_if.sv
// rtl/link_collision_detector_if.sv - request, terrain-map and result signals of the collision detector
interface link_collision_detector_if;
    logic        start;
    logic [8:0]  x_pos;
    logic [7:0]  y_pos;
    logic [2:0]  direction;
    logic [26:0] enemy_x;
    logic [23:0] enemy_y;
    logic [2:0]  enemy_active;
    logic        map_rd;
    logic [16:0] map_addr;
    logic        map_data;
    logic [3:0]  collision;
    logic        busy;
    logic        done;

    modport master (
        output start, x_pos, y_pos, direction, enemy_x, enemy_y, enemy_active, map_data,
        input  map_rd, map_addr, collision, busy, done
    );

    modport slave (
        input  start, x_pos, y_pos, direction, enemy_x, enemy_y, enemy_active, map_data,
        output map_rd, map_addr, collision, busy, done
    );
endinterface

// File: rtl/link_collision_detector.sv
// rtl/link_collision_detector.sv - terrain leading-edge scan and enemy box overlap for link
module link_collision_detector #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int SPRITE   = 16
) (
    input logic clock,
    input logic reset,
    link_collision_detector_if.slave lnk
);
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_ENEMY, S_DONE} state_t;

    localparam logic [2:0] D_UP    = 3'b010;
    localparam logic [2:0] D_DOWN  = 3'b011;
    localparam logic [2:0] D_LEFT  = 3'b100;
    localparam logic [2:0] D_RIGHT = 3'b101;

    localparam logic [9:0]        X_MAX = 10'(SCREEN_W - 1);
    localparam logic [9:0]        Y_MAX = 10'(SCREEN_H - 1);
    localparam logic [9:0]        SPR   = 10'(SPRITE);
    localparam logic signed [9:0] LIM   = 10'(SPRITE);

    state_t      state, state_nxt;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [2:0]  dir_q;
    logic [26:0] ex_q;
    logic [23:0] ey_q;
    logic [2:0]  ea_q;
    logic [3:0]  k_q;
    logic [1:0]  e_q;
    logic        blocked_q;
    logic [2:0]  hit_q;
    logic        rd_q;
    logic [3:0]  collision_q;

    logic        moving, edge_off;
    logic [9:0]  px, py;
    logic        probe_ok;
    logic [16:0] probe_addr;
    logic [8:0]  ex_sel;
    logic [7:0]  ey_sel;
    logic        ea_sel, hit_now;
    logic signed [9:0] dx, dy;
    logic [2:0]  hit_vec;
    logic        map_rd_c;

    // Decode the incoming request: is it a move, and is its whole probe edge off-screen?
    always_comb begin
        moving   = 1'b0;
        edge_off = 1'b0;
        case (lnk.direction)
            D_UP:    begin moving = 1'b1; edge_off = (lnk.y_pos == 8'd0); end
            D_DOWN:  begin moving = 1'b1; edge_off = ({2'b0, lnk.y_pos} + SPR) > Y_MAX; end
            D_LEFT:  begin moving = 1'b1; edge_off = (lnk.x_pos == 9'd0); end
            D_RIGHT: begin moving = 1'b1; edge_off = ({1'b0, lnk.x_pos} + SPR) > X_MAX; end
            default: begin moving = 1'b0; edge_off = 1'b0; end
        endcase
    end

    // Probe pixel k on the leading edge and its bitmap address.
    always_comb begin
        px = 10'd0;
        py = 10'd0;
        case (dir_q)
            D_UP:    begin px = {1'b0, x_q} + {6'b0, k_q}; py = {2'b0, y_q} - 10'd1; end
            D_DOWN:  begin px = {1'b0, x_q} + {6'b0, k_q}; py = {2'b0, y_q} + SPR; end
            D_LEFT:  begin px = {1'b0, x_q} - 10'd1; py = {2'b0, y_q} + {6'b0, k_q}; end
            D_RIGHT: begin px = {1'b0, x_q} + SPR; py = {2'b0, y_q} + {6'b0, k_q}; end
            default: begin px = 10'd0; py = 10'd0; end
        endcase
        probe_ok   = (px <= X_MAX) && (py <= Y_MAX);
        probe_addr = 17'(py) * 17'(SCREEN_W) + 17'(px);
    end

    // Box overlap of link against the enemy selected by e_q.
    always_comb begin
        ex_sel = ex_q[8:0];
        ey_sel = ey_q[7:0];
        ea_sel = ea_q[0];
        case (e_q)
            2'd1:    begin ex_sel = ex_q[17:9];  ey_sel = ey_q[15:8];  ea_sel = ea_q[1]; end
            2'd2:    begin ex_sel = ex_q[26:18]; ey_sel = ey_q[23:16]; ea_sel = ea_q[2]; end
            default: begin ex_sel = ex_q[8:0];   ey_sel = ey_q[7:0];   ea_sel = ea_q[0]; end
        endcase
        dx      = $signed({1'b0, x_q} - {1'b0, ex_sel});
        dy      = $signed({2'b0, y_q} - {2'b0, ey_sel});
        hit_now = ea_sel && (dx < LIM) && (dx > -LIM) && (dy < LIM) && (dy > -LIM);
        hit_vec = hit_q | (3'(hit_now) << e_q);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and status outputs.
    always_comb begin
        state_nxt    = state;
        map_rd_c     = 1'b0;
        lnk.map_rd   = 1'b0;
        lnk.map_addr = 17'd0;
        lnk.busy     = 1'b0;
        lnk.done     = 1'b0;
        case (state)
            S_IDLE:  if (lnk.start) state_nxt = (moving && !edge_off) ? S_SCAN : S_ENEMY;
            S_SCAN:  begin
                lnk.busy = 1'b1;
                map_rd_c = probe_ok;
                if (k_q == 4'd15) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin lnk.busy = 1'b1; state_nxt = S_ENEMY; end
            S_ENEMY: begin lnk.busy = 1'b1; if (e_q == 2'd2) state_nxt = S_DONE; end
            S_DONE:  begin lnk.done = 1'b1; state_nxt = S_IDLE; end
            default: state_nxt = S_IDLE;
        endcase
        lnk.map_rd   = map_rd_c;
        lnk.map_addr = map_rd_c ? probe_addr : 17'd0;
    end

    // Request latch, blocked/hit accumulation and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0; y_q <= '0; dir_q <= '0;
            ex_q <= '0; ey_q <= '0; ea_q <= '0;
            k_q <= '0; e_q <= '0;
            blocked_q <= 1'b0; hit_q <= '0; rd_q <= 1'b0;
            collision_q <= '0;
        end else begin
            rd_q <= map_rd_c;
            // map_data answers the read issued one cycle earlier
            if (rd_q && lnk.map_data) blocked_q <= 1'b1;
            case (state)
                S_IDLE: if (lnk.start) begin
                    x_q <= lnk.x_pos; y_q <= lnk.y_pos; dir_q <= lnk.direction;
                    ex_q <= lnk.enemy_x; ey_q <= lnk.enemy_y; ea_q <= lnk.enemy_active;
                    k_q <= '0; e_q <= '0; hit_q <= '0; rd_q <= 1'b0;
                    blocked_q <= moving && edge_off;
                end
                S_SCAN: begin
                    k_q <= k_q + 4'd1;
                    if (!probe_ok) blocked_q <= 1'b1;
                end
                S_ENEMY: begin
                    hit_q <= hit_vec;
                    e_q   <= e_q + 2'd1;
                    if (e_q == 2'd2) collision_q <= {hit_vec, blocked_q};
                end
                default: ;
            endcase
        end
    end

    assign lnk.collision = collision_q;
endmodule

// File: tb/tb_link_collision_detector.sv
// tb/tb_link_collision_detector.sv - directed scoreboard bench for link_collision_detector
module tb_link_collision_detector;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [16:0] blk_addr = 17'h1FFFF;
    logic [16:0] addr_q[$];
    logic [3:0]  coll_q[$];
    int          lat_q[$];

    link_collision_detector_if lnk();

    link_collision_detector dut (
        .clock (clock),
        .reset (reset),
        .lnk   (lnk)
    );

    always #5 clock = ~clock;

    // Terrain bitmap: a single blocked pixel at blk_addr, answering one cycle after the read
    always @(posedge clock) lnk.map_data <= lnk.map_rd && (lnk.map_addr == blk_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] x, input logic [7:0] y, input logic [2:0] dir,
                         input logic [26:0] ex, input logic [23:0] ey, input logic [2:0] ea);
        lnk.x_pos = x; lnk.y_pos = y; lnk.direction = dir;
        lnk.enemy_x = ex; lnk.enemy_y = ey; lnk.enemy_active = ea;
        lnk.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        lnk.start = 1'b0;
    endtask

    task automatic push_col(input int px, input int py0);
        for (int k = 0; k < 16; k++) addr_q.push_back(17'((py0 + k) * 320 + px));
    endtask

    task automatic expect_done(input logic [3:0] coll, input int lat);
        coll_q.push_back(coll);
        lat_q.push_back(lat);
    endtask

    // Entered at the negedge of cycle 1; returns at the negedge of the done cycle
    task automatic watch(input string tag, input int inject_cyc);
        bit seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (cyc == 1) chk({tag, ".busy_c1"}, lnk.busy, 1);
            if (cyc == inject_cyc) begin
                lnk.start = 1'b1;
                lnk.direction = 3'b001;
            end else begin
                lnk.start = 1'b0;
            end
            if (lnk.map_rd) begin
                if (addr_q.size() == 0) chk({tag, ".map_rd"}, lnk.map_rd, 0);
                else chk({tag, ".map_addr"}, lnk.map_addr, addr_q.pop_front());
            end
            if (lnk.done) begin
                seen = 1'b1;
                chk({tag, ".latency"}, cyc, lat_q.pop_front());
                chk({tag, ".collision"}, lnk.collision, coll_q.pop_front());
                chk({tag, ".busy_done"}, lnk.busy, 0);
            end else begin
                @(negedge clock);
            end
        end
        lnk.start = 1'b0;
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".addr_left"}, addr_q.size(), 0);
        addr_q.delete();
    endtask

    initial begin
        int dones;
        lnk.start = 1'b0; lnk.x_pos = '0; lnk.y_pos = '0; lnk.direction = '0;
        lnk.enemy_x = '0; lnk.enemy_y = '0; lnk.enemy_active = '0;
        repeat (3) @(negedge clock);
        chk("rst.collision", lnk.collision, 0);
        chk("rst.done", lnk.done, 0);
        chk("rst.busy", lnk.busy, 0);
        chk("rst.map_rd", lnk.map_rd, 0);
        chk("rst.map_addr", lnk.map_addr, 0);
        reset = 1'b0;
        @(negedge clock);

        // Move right past a wall pixel at (116,57)
        blk_addr = 17'(57 * 320 + 116);
        push_col(116, 50);
        expect_done(4'b0001, 21);
        drive(9'd100, 8'd50, 3'b101, 27'd0, 24'd0, 3'b000);
        watch("right", 0);

        // Move up from the top row: blocked without reading
        @(negedge clock);
        expect_done(4'b0001, 4);
        drive(9'd40, 8'd0, 3'b010, 27'd0, 24'd0, 3'b000);
        watch("up_edge", 0);

        // Attack with overlapping enemy 0, then the same enemy inactive
        @(negedge clock);
        expect_done(4'b0010, 4);
        drive(9'd100, 8'd50, 3'b001, {9'd0, 9'd0, 9'd110}, {8'd0, 8'd0, 8'd60}, 3'b001);
        watch("attack_hit", 0);
        @(negedge clock);
        expect_done(4'b0000, 4);
        drive(9'd100, 8'd50, 3'b001, {9'd0, 9'd0, 9'd110}, {8'd0, 8'd0, 8'd60}, 3'b000);
        watch("attack_off", 0);

        // Move left; enemy2 edge-touching, enemy1 just inside
        @(negedge clock);
        blk_addr = 17'h1FFFF;
        push_col(49, 50);
        expect_done(4'b0100, 21);
        drive(9'd50, 8'd50, 3'b100, {9'd66, 9'd35, 9'd200}, {8'd50, 8'd65, 8'd200}, 3'b111);
        watch("left_enemy", 0);

        // Reset in the middle of a scan
        @(negedge clock);
        drive(9'd100, 8'd50, 3'b101, 27'd0, 24'd0, 3'b000);
        repeat (7) @(negedge clock);
        chk("midrst.scanning", lnk.map_rd, 1);
        reset = 1'b1;
        #1;
        chk("midrst.collision", lnk.collision, 0);
        chk("midrst.busy", lnk.busy, 0);
        chk("midrst.done", lnk.done, 0);
        chk("midrst.map_rd", lnk.map_rd, 0);
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (lnk.done) dones++;
        end
        chk("midrst.no_done", dones, 0);

        // Start while busy is ignored; start right after done is accepted
        blk_addr = 17'(57 * 320 + 116);
        push_col(116, 50);
        expect_done(4'b0001, 21);
        drive(9'd100, 8'd50, 3'b101, 27'd0, 24'd0, 3'b000);
        watch("busy_start", 5);
        @(negedge clock);
        expect_done(4'b0010, 4);
        drive(9'd100, 8'd50, 3'b001, {9'd0, 9'd0, 9'd110}, {8'd0, 8'd0, 8'd60}, 3'b001);
        watch("back2back", 0);
        repeat (3) @(negedge clock);
        chk("final.idle_busy", lnk.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/link_collision_detector.md
Name: link_collision_detector

Overview:
- Computes the 4-bit collision vector consumed by the player character block. It sits between link movement and the terrain map / enemy blocks.
- On a start pulse it latches link position and intended direction.
- It scans the 16 pixels of the leading edge in a 1-bit terrain bitmap (1 = blocked) and checks 16x16 box overlap against up to 3 enemies.
- It returns collision[0] (terrain blocked) and collision[3:1] (enemy contact), then pulses done.

Parameters:
SCREEN_W, 320, screen width in pixels; valid x range 0..SCREEN_W-1
SCREEN_H, 240, screen height in pixels; valid y range 0..SCREEN_H-1
SPRITE, 16, sprite edge length in pixels (link and enemies)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
x_pos  in  9  link top-left x
y_pos  in  8  link top-left y
direction  in  3  000 none, 001 attack, 010 up, 011 down, 100 left, 101 right; 110/111 = none
enemy_x  in  27  {e2,e1,e0} x positions, 9 bits each
enemy_y  in  24  {e2,e1,e0} y positions, 8 bits each
enemy_active  in  3  bit n = enemy n present
map_rd  out  1  terrain read strobe
map_addr  out  17  terrain bitmap address = y*SCREEN_W + x
map_data  in  1  terrain bit, valid exactly 1 cycle after map_rd/map_addr
collision  out  4  [0] terrain blocked, [n+1] overlap with enemy n
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when collision is updated

Behaviour:
- Reset state (asynchronous): state=IDLE, collision=0, done=0, busy=0, map_rd=0, map_addr=0.
- Reset mid-operation aborts the request; no done is produced.
- States: IDLE, SCAN, DRAIN, ENEMY, DONE.
- IDLE, on start (cycle 0):
  - Latch all inputs; enemy inputs are not re-read after cycle 0.
  - Clear the internal blocked and hit accumulators.
  - If direction is up/down/left/right and the probe edge is on-screen, go to SCAN.
  - Otherwise go to ENEMY.
- Start while busy is ignored.
- Probe edge, for k = 0..15:
  - up: (x+k, y-1)
  - down: (x+k, y+16)
  - left: (x-1, y+k)
  - right: (x+16, y+k)
- Off-screen rule, evaluated with 10-bit arithmetic:
  - up with y==0, down with y+16>SCREEN_H-1, left with x==0, or right with x+16>SCREEN_W-1 sets blocked=1 without scanning.
  - Probe coordinates along the edge that exceed the screen (x+k>SCREEN_W-1, y+k>SCREEN_H-1) are treated as blocked and are not read.
- Address arithmetic: map_addr = (y<<8)+(y<<6)+x in 17 bits, no wrap; the maximum 76799 fits.
- SCAN, cycles 1..16: map_rd=1 and map_addr = probe k=cycle-1.
- DRAIN, cycle 17: map_rd=0; the last data is captured.
- map_data for probe k is sampled in cycle k+2; blocked |= map_data.
- No early exit: latency is fixed.
- ENEMY, 3 cycles, checks enemy 0, 1, 2 in order.
  - Enemy n sets hit[n] iff enemy_active[n], |x-ex|<16 and |y-ey|<16.
  - Use signed 10-bit differences.
  - The check uses the current position, not the probe edge.
  - An edge-touching case (|dx|==16) does not hit.
- DONE: collision <= {hit[2:0], blocked}, done=1 for one cycle, busy=0, then IDLE.
- collision holds its value until the next DONE.
- Latency from start (cycle 0):
  - Moving and in-bounds: done at cycle 21.
  - none/attack/off-screen: done at cycle 4.
- Start may be re-asserted in the cycle after done; it is accepted.

Test Plan:
- Reset asserted mid-SCAN at cycle 8 -> collision=0, busy=0, done=0 immediately (asynchronous); no done pulse after release.
- Move right, x=100, y=50, bitmap all zero except (116,57)=1 -> map_addr sequence 16116..20916 stepping 320; collision=4'b0001; done at cycle 21.
- Move up, x=40, y=0 -> no map_rd; collision[0]=1; done at cycle 4.
- direction=attack, enemy0 at (110,60) active, link at (100,50) -> collision=4'b0010, done at cycle 4; same with enemy_active=0 -> 4'b0000.
- Move left, x=50, y=50, enemy2 at (66,50) (|dx|=16), enemy1 at (35,65) (dx=-15, dy=15), all active, bitmap clear -> collision=4'b0100.
- start re-asserted at cycle 5 of a busy scan -> ignored, one done only; start in the cycle after done -> accepted.
